uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART chip, the downstream counterpart of the transmit path. It consumes the asynchronous serial line (8N1, LSB first, idle high), oversamples it using a tick strobe from a `baud_gen` instance running at `BAUD*OVERSAMPLE`, and presents each received byte with a one-cycle valid pulse. A framing-error pulse is raised when the stop bit is low. In loopback, this block's `rx` connects directly to the transmitter's `tx`.

## Interface
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥ 8.
- `DATA_BITS`, 8: data bits per frame.

Clock and reset: one clock domain, `clk`. Reset `rst` is synchronous and active-high.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `rx`  in  1  asynchronous serial input; idle is high.
- `tick`  in  1  oversample strobe, one `clk` wide, at `BAUD*OVERSAMPLE`.
- `data_out`  out  DATA_BITS  last correctly framed byte; held until the next valid frame.
- `valid`  out  1  one-cycle pulse when `data_out` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input synchronizer: `rx` passes through 2 flops to produce `rx_s`. Both flops reset to 1.
- Counters:
  - `os_cnt` is `$clog2(OVERSAMPLE)` bits wide and increments only on `tick`.
  - `bit_idx` is `$clog2(DATA_BITS)` bits wide.
  - The shift register is DATA_BITS wide. It shifts right, with the new bit entering at the MSB, so the first received bit ends up at the LSB.
- States:
  - IDLE: when `rx_s==0`, go to START and clear `os_cnt`.
  - START: on the tick where `os_cnt==OVERSAMPLE/2-1` (mid start bit), sample `rx_s`.
    - If 0: go to DATA; clear `os_cnt` and `bit_idx`.
    - If 1: false start; go to IDLE with no output pulse.
  - DATA: on the tick where `os_cnt==OVERSAMPLE-1`, shift in `rx_s` and clear `os_cnt`.
    - If `bit_idx==DATA_BITS-1`: go to STOP.
    - Otherwise: increment `bit_idx`.
  - STOP: on the tick where `os_cnt==OVERSAMPLE-1`, sample `rx_s`.
    - If 1: load `data_out` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data_out` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s==1`, then go to IDLE. This keeps a break condition from retriggering the receiver.
- Single-sample decision at mid-bit; no majority vote.
- `tick` is ignored in IDLE and WAIT_IDLE.
- If `rst` and `tick` are asserted in the same cycle, reset wins.
- Reset mid-frame: the receiver returns to IDLE immediately and the partial byte is discarded. It then rearms on the next low level of `rx_s`; if the line is already low mid-frame, this can misframe, which is accepted.

## Timing
- Reset values:
  - `data_out=0`, `valid=0`, `frame_err=0`, `busy=0`.
  - State IDLE; `os_cnt=0`, `bit_idx=0`.
- Start detection: `busy` rises 3 clk after the `rx` falling edge (2 synchronizer cycles plus the state register).
- Output pulses: `valid` and `frame_err` assert in the `clk` cycle after the stop-sample tick, for exactly 1 cycle. `busy` falls in that same cycle.
- Frame length: the stop sample occurs `OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE` ticks after start detection, i.e. 152 ticks at the defaults.
- Back-to-back frames: the next start bit can be detected in the cycle immediately after returning to IDLE. This leaves about half a bit of margin, so zero-gap frames are supported.
- `valid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Default constants `UART_OVERSAMPLE=16` and `UART_DATA_BITS=8`.
- Sub-module `rx_sync`: a 2-flop synchronizer with a reset-value parameter, reusable for other asynchronous inputs.
- Tick source: the top level instantiates the existing `baud_gen` with `BAUD=BAUDS*OVERSAMPLE`. This block does not contain its own tick divider.

## Test plan
Bench settings: `OVERSAMPLE=16`, with `tick` every 4 clk.

- **Nominal byte:** drive frame 0xA5 (line sequence 0, 1,0,1,0,0,1,0,1, 1).
  - Expect a single `valid` pulse with `data_out=0xA5`, `frame_err=0`.
  - `busy` low again in the same cycle as `valid`.
- **Glitch rejection:** drive `rx` low for 3 ticks, then high.
  - Expect no `valid` and no `frame_err`.
  - `busy` pulses and then returns to 0 after the mid-start sample.
- **Framing error:** drive 0x3C with a stop bit of 0, holding the line low for 20 more ticks.
  - Expect one `frame_err` pulse, no `valid`, and `data_out` holding its previous value.
  - No new frame starts until `rx` goes high.
  - A following frame 0x3C with a correct stop bit then gives `valid` with `data_out=0x3C`.
- **Back-to-back:** drive 0x00 then 0xFF with no idle gap.
  - Expect two `valid` pulses, 160 ticks apart, with `data_out` 0x00 then 0xFF.
- **Reset mid-frame:** assert `rst` for 1 clk during data bit 3 of 0x81.
  - Expect all outputs at their reset values and no pulse for 0x81.
  - The next clean frame 0x42 gives `valid` with `data_out=0x42`.
- **Loopback:** connect to `uart_tx` driven from a shared `baud_gen`-derived tick.
  - Send 0x55 via `en`.
  - Expect `valid` with `data_out=0x55` and no `frame_err`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level input, with a selectable
// reset value so idle-high and idle-low lines both come out of reset quiet.
module rx_sync import uart_pkg::*; #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start detection, single mid-bit sample per
// bit, one-cycle valid / frame_err pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low level on rx_s
// START     | counting to mid start bit to confirm it is still low
// DATA      | sampling data bits at mid-bit, LSB first
// STOP      | sampling the stop bit; high commits the byte
// WAIT_IDLE | stop bit was low; wait for the line to return high
module uart_rx import uart_pkg::*; #(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 tick,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BIT_LAST = BI_W'(DATA_BITS - 1);

    rx_state_t            state, state_n;
    logic [OS_W-1:0]      os_cnt, os_cnt_n;
    logic [BI_W-1:0]      bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, frame_err_n;
    logic                 rx_s;

    rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign busy = (state != IDLE);

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            os_cnt    <= os_cnt_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            data_out  <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    // Next-state and datapath decisions; ticks only matter mid-frame.
    always_comb begin
        state_n     = state;
        os_cnt_n    = os_cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data_out;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n  = START;
                    os_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt == OS_MID) begin
                        if (!rx_s) begin
                            state_n   = DATA;
                            os_cnt_n  = '0;
                            bit_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        shift_n  = {rx_s, shift[DATA_BITS-1:1]};
                        os_cnt_n = '0;
                        if (bit_idx == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_idx_n = bit_idx + BI_W'(1);
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_cnt == OS_LAST) begin
                        os_cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shift;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = WAIT_IDLE;
                        end
                    end else begin
                        os_cnt_n = os_cnt + OS_W'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a tick-counting line model predicts every output each
// cycle; directed frames pin the model with literal expectations, then a
// randomized stream of frames, glitches, framing errors and resets follows.
module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       tick;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int tick_no = 0;
    int ferr_cnt = 0;
    bit busy_seen = 0;
    logic [7:0] vq[$];
    int         vt[$];

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .tick      (tick),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // tick: one clk wide, every 4 clk, changed on the falling edge
    initial begin
        int ph;
        ph = 0;
        tick = 1'b0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (tick) tick_no++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       p1 = 1'b1, p2 = 1'b1;
    logic       m_valid = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;
    logic [7:0] m_data = 8'h00;

    // One clock edge as the receiver sees it: the line is seen two edges late.
    task automatic mstep(output logic rs, output logic tk, output logic r);
        @(posedge clk);
        rs = p2;
        tk = tick;
        r  = rst;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        if (r) begin
            p1 = 1'b1;
            p2 = 1'b1;
            m_busy = 1'b0;
            m_data = 8'h00;
        end else begin
            p2 = p1;
            p1 = rx;
        end
    endtask

    // Advance to the n-th tick and return the line level seen there.
    task automatic mwait(input int n, output logic s, output bit ab);
        int cnt;
        logic rs, tk, r;
        cnt = 0;
        s = 1'b1;
        ab = 1'b0;
        while (1) begin
            mstep(rs, tk, r);
            if (r) begin
                ab = 1'b1;
                return;
            end
            if (tk) begin
                cnt++;
                if (cnt == n) begin
                    s = rs;
                    return;
                end
            end
        end
    endtask

    initial begin : model
        logic rs, tk, r, s;
        bit ab;
        logic [7:0] v;
        v = 8'h00;
        while (1) begin
            m_busy = 1'b0;
            while (1) begin
                mstep(rs, tk, r);
                if (!r && !rs) break;
            end
            m_busy = 1'b1;
            mwait(OS / 2, s, ab);
            if (ab) continue;
            if (s) continue;
            for (int i = 0; i < 8; i++) begin
                mwait(OS, s, ab);
                if (ab) break;
                v[i] = s;
            end
            if (ab) continue;
            mwait(OS, s, ab);
            if (ab) continue;
            if (s) begin
                m_data  = v;
                m_valid = 1'b1;
                continue;
            end
            m_ferr = 1'b1;
            while (1) begin
                mstep(rs, tk, r);
                if (r || rs) break;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cycle", 32'({valid, frame_err, busy, data_out}),
                32'({m_valid, m_ferr, m_busy, m_data}));
        end
    end

    // Event log of DUT pulses for the directed literal checks
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                vq.push_back(data_out);
                vt.push_back(tick_no);
            end
            if (frame_err) ferr_cnt++;
            if (busy) busy_seen = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic hold_ticks(input int n);
        int k;
        if (n <= 0) return;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (tick) k++;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int extra_low, input int rst_bit);
        rx = 1'b0;
        hold_ticks(OS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == rst_bit) begin
                hold_ticks(4);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("rst_valid", 32'(valid), 0);
                chk("rst_ferr", 32'(frame_err), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_data", 32'(data_out), 0);
                hold_ticks(OS - 4);
            end else begin
                hold_ticks(OS);
            end
        end
        rx = stop_bit;
        hold_ticks(OS);
        if (!stop_bit) hold_ticks(extra_low);
        rx = 1'b1;
    endtask

    initial begin
        int n0, f0, c;
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_ferr", 32'(frame_err), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_data", 32'(data_out), 0);
        rst = 1'b0;
        hold_ticks(20);

        // nominal byte, with start-detection latency
        n0 = vq.size();
        f0 = ferr_cnt;
        fork
            send_frame(8'hA5, 1'b1, 0, -1);
            begin
                int d;
                d = 0;
                while (!busy && d < 10) begin
                    @(negedge clk);
                    d++;
                end
                chk("busy_rise_latency", 32'(d), 3);
            end
        join
        hold_ticks(4);
        chk("nominal_count", 32'(vq.size() - n0), 1);
        if (vq.size() > n0) chk("nominal_data", 32'(vq[n0]), 32'h A5);
        chk("nominal_ferr", 32'(ferr_cnt - f0), 0);

        // glitch rejection
        n0 = vq.size();
        busy_seen = 1'b0;
        rx = 1'b0;
        hold_ticks(3);
        rx = 1'b1;
        hold_ticks(16);
        chk("glitch_valid", 32'(vq.size() - n0), 0);
        chk("glitch_ferr", 32'(ferr_cnt - f0), 0);
        chk("glitch_busy_seen", 32'(busy_seen), 1);
        chk("glitch_busy_end", 32'(busy), 0);

        // framing error, then a good frame
        send_frame(8'h3C, 1'b0, 20, -1);
        chk("ferr_wait_busy", 32'(busy), 1);
        hold_ticks(4);
        chk("ferr_count", 32'(ferr_cnt - f0), 1);
        chk("ferr_no_valid", 32'(vq.size() - n0), 0);
        chk("ferr_data_hold", 32'(data_out), 32'hA5);
        hold_ticks(8);
        send_frame(8'h3C, 1'b1, 0, -1);
        hold_ticks(4);
        chk("after_ferr_count", 32'(vq.size() - n0), 1);
        chk("after_ferr_data", 32'(data_out), 32'h3C);

        // back-to-back
        n0 = vq.size();
        send_frame(8'h00, 1'b1, 0, -1);
        send_frame(8'hFF, 1'b1, 0, -1);
        hold_ticks(4);
        chk("b2b_count", 32'(vq.size() - n0), 2);
        if (vq.size() >= n0 + 2) begin
            chk("b2b_first", 32'(vq[n0]), 32'h00);
            chk("b2b_second", 32'(vq[n0 + 1]), 32'hFF);
            chk("b2b_gap_ticks", 32'(vt[n0 + 1] - vt[n0]), 160);
        end

        // reset during data bit 3 of 0x81, then a clean frame
        n0 = vq.size();
        send_frame(8'h81, 1'b1, 0, 3);
        hold_ticks(64);
        c = 0;
        for (int i = n0; i < vq.size(); i++) if (vq[i] == 8'h81) c++;
        chk("rst_no_81", 32'(c), 0);
        n0 = vq.size();
        send_frame(8'h42, 1'b1, 0, -1);
        hold_ticks(4);
        chk("after_rst_count", 32'(vq.size() - n0), 1);
        chk("after_rst_data", 32'(data_out), 32'h42);

        // loopback-style frame from a tick-timed transmitter
        n0 = vq.size();
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b1, 0, -1);
        hold_ticks(4);
        chk("loop_count", 32'(vq.size() - n0), 1);
        chk("loop_data", 32'(data_out), 32'h55);
        chk("loop_ferr", 32'(ferr_cnt - f0), 0);

        // randomized traffic, checked cycle by cycle against the model
        for (int f = 0; f < 30; f++) begin
            int kind;
            logic [7:0] b;
            kind = int'($urandom_range(0, 99));
            b = 8'($urandom);
            if (kind < 10) begin
                rx = 1'b0;
                hold_ticks(int'($urandom_range(1, 6)));
                rx = 1'b1;
                hold_ticks(12);
            end else if (kind < 25) begin
                send_frame(b, 1'b0, int'($urandom_range(0, 20)), -1);
            end else if (kind < 33) begin
                send_frame(b, 1'b1, 0, int'($urandom_range(0, 7)));
            end else begin
                send_frame(b, 1'b1, 0, -1);
            end
            hold_ticks(int'($urandom_range(0, 24)));
        end
        rx = 1'b1;
        hold_ticks(200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
